// File: rtl/interleave_fifo_ctrl.sv
// Round-robin interleaver/gatherer across NUM_BANKS FIFO banks.
// Optional level flags: define ILV_FIFO_LEVEL_FLAGS_EN.
module interleave_fifo_ctrl #(
    parameter int DATA_WIDTH     = 8,
    parameter int NUM_BANKS      = 2,
    parameter int BANK_DEPTH     = 256,
    parameter int LB_NUM_BANKS   = $clog2(NUM_BANKS),
    parameter int TOTAL_DEPTH    = NUM_BANKS*BANK_DEPTH+1,
    parameter int LB_TOTAL_DEPTH = $clog2(TOTAL_DEPTH)
`ifdef ILV_FIFO_LEVEL_FLAGS_EN
    ,
    parameter int AFULL_TH       = TOTAL_DEPTH-4,
    parameter int AEMPTY_TH      = 4
`endif
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic [DATA_WIDTH-1:0]           in_data,
    input  logic                            in_valid,
    output logic                            in_ready,
    output logic [DATA_WIDTH-1:0]           out_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    input  logic                            clear,
    output logic [LB_TOTAL_DEPTH:0]         count,
    output logic [NUM_BANKS*DATA_WIDTH-1:0] bank_in_data,
    output logic [NUM_BANKS-1:0]            bank_in_valid,
    input  logic [NUM_BANKS-1:0]            bank_in_ready,
    input  logic [NUM_BANKS*DATA_WIDTH-1:0] bank_out_data,
    input  logic [NUM_BANKS-1:0]            bank_out_valid,
    output logic [NUM_BANKS-1:0]            bank_out_ready,
    output logic                            bank_clear
`ifdef ILV_FIFO_LEVEL_FLAGS_EN
    ,
    output logic                            almost_full,
    output logic                            almost_empty
`endif
);

    localparam int CW = LB_TOTAL_DEPTH + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(TOTAL_DEPTH);
    localparam logic [LB_NUM_BANKS-1:0] SEL_LAST = LB_NUM_BANKS'(NUM_BANKS-1);

    logic [LB_NUM_BANKS-1:0] wr_sel_r;
    logic [LB_NUM_BANKS-1:0] rd_sel_r;
    logic [CW-1:0]           count_r;
    logic [CW-1:0]           count_nxt;
    logic [DATA_WIDTH-1:0]   bank_rd [NUM_BANKS];
    logic                    load;
    logic                    take;
    logic                    in_exec;
    logic                    out_exec;

    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_slice
        assign bank_rd[g] = bank_out_data[g*DATA_WIDTH +: DATA_WIDTH];
    end

    assign bank_in_data = {NUM_BANKS{in_data}};
    assign bank_clear   = clear;
    assign load         = ~out_valid | out_ready;
    assign count        = count_r;
    assign in_exec      = in_valid & in_ready;
    assign out_exec     = out_valid & out_ready;

    // Steer handshakes to the currently selected write and read banks.
    always_comb begin
        bank_in_valid            = '0;
        bank_out_ready           = '0;
        bank_in_valid[wr_sel_r]  = in_valid & ~clear;
        bank_out_ready[rd_sel_r] = load & ~clear;
        in_ready = bank_in_ready[wr_sel_r] & (count_r < FULL_CNT) & ~clear;
        take     = bank_out_valid[rd_sel_r] & load & ~clear;
    end

    // Occupancy follows accepted writes minus delivered reads.
    always_comb begin
        count_nxt = count_r;
        unique case ({in_exec, out_exec})
            2'b10:   count_nxt = count_r + 1'b1;
            2'b01:   count_nxt = count_r - 1'b1;
            default: count_nxt = count_r;
        endcase
    end

    // Round-robin bank pointers; each wraps after the last bank.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_sel_r <= '0;
            rd_sel_r <= '0;
        end else if (clear) begin
            wr_sel_r <= '0;
            rd_sel_r <= '0;
        end else begin
            if (in_exec)
                wr_sel_r <= (wr_sel_r == SEL_LAST) ? '0 : wr_sel_r + 1'b1;
            if (take)
                rd_sel_r <= (rd_sel_r == SEL_LAST) ? '0 : rd_sel_r + 1'b1;
        end
    end

    // Output register: load on take, drop when consumed, else hold.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (clear) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (take) begin
            out_valid <= 1'b1;
            out_data  <= bank_rd[rd_sel_r];
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Global occupancy register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            count_r <= '0;
        else if (clear)
            count_r <= '0;
        else
            count_r <= count_nxt;
    end

`ifdef ILV_FIFO_LEVEL_FLAGS_EN
    // Level flags track the value count_r takes on the same edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else if (clear) begin
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            almost_full  <= count_nxt >= CW'(AFULL_TH);
            almost_empty <= count_nxt <= CW'(AEMPTY_TH);
        end
    end
`endif

endmodule

// File: tb/tb_interleave_fifo_ctrl.sv
// Bench for interleave_fifo_ctrl: queue-based banks, global-order model.
// Randomized traffic plus directed scenarios with literal expectations.
module tb_interleave_fifo_ctrl;

    localparam int DW = 8;
    localparam int NB = 2;
    localparam int BD = 256;
    localparam int TD = NB*BD+1;
    localparam int CW = $clog2(TD)+1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rstn;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          clear;
    logic [CW-1:0] count;
    logic [NB*DW-1:0] bank_in_data;
    logic [NB-1:0] bank_in_valid;
    logic [NB-1:0] bank_in_ready;
    logic [NB*DW-1:0] bank_out_data;
    logic [NB-1:0] bank_out_valid;
    logic [NB-1:0] bank_out_ready;
    logic          bank_clear;
`ifdef ILV_FIFO_LEVEL_FLAGS_EN
    logic          almost_full;
    logic          almost_empty;
`endif

    interleave_fifo_ctrl #(
        .DATA_WIDTH(DW),
        .NUM_BANKS (NB),
        .BANK_DEPTH(BD)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .clear         (clear),
        .count         (count),
        .bank_in_data  (bank_in_data),
        .bank_in_valid (bank_in_valid),
        .bank_in_ready (bank_in_ready),
        .bank_out_data (bank_out_data),
        .bank_out_valid(bank_out_valid),
        .bank_out_ready(bank_out_ready),
        .bank_clear    (bank_clear)
`ifdef ILV_FIFO_LEVEL_FLAGS_EN
        ,
        .almost_full   (almost_full),
        .almost_empty  (almost_empty)
`endif
    );

    // bank storage (environment) and logs
    logic [DW-1:0] bq   [NB][$];
    logic [DW-1:0] blog [NB][$];
    logic [DW-1:0] olog [$];
    // reference model: every accepted, undelivered word in global order
    logic [DW-1:0] ref_q [$];
    logic [NB-1:0] stall_in;
    logic [NB-1:0] stall_out;
    int   n_wr;
    int   n_take;
    int   exp_cnt;
    logic exp_ov;
    int   n_pass;
    int   n_chk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic logic [63:0] pack(input logic [DW-1:0] q[$]);
        logic [63:0] r;
        r = '0;
        foreach (q[i]) r = (r << DW) | 64'(q[i]);
        return r;
    endfunction

    task automatic drive_banks();
        for (int i = 0; i < NB; i++) begin
            bank_in_ready[i]  = (bq[i].size() < BD) && !stall_in[i];
            bank_out_valid[i] = (bq[i].size() > 0) && !stall_out[i];
            bank_out_data[i*DW +: DW] = (bq[i].size() > 0) ? bq[i][0] : '0;
        end
    endtask

    task automatic model_reset();
        n_wr = 0;
        n_take = 0;
        exp_cnt = 0;
        exp_ov = 1'b0;
        ref_q.delete();
        for (int i = 0; i < NB; i++) bq[i].delete();
    endtask

    task automatic clear_logs();
        olog.delete();
        for (int i = 0; i < NB; i++) blog[i].delete();
    endtask

    // one clock: check at negedge, advance model and banks after posedge
    task automatic step();
        int wb;
        int rb;
        logic ld, cl, ie, oe, tk, rdy, ordy;
        logic [NB-1:0] e_biv, e_bor, biv, bir, bov, bor;
        logic [DW-1:0] din;
        drive_banks();
        @(negedge clk);
        wb = n_wr % NB;
        rb = n_take % NB;
        cl = clear;
        ld = !exp_ov || out_ready;
        rdy = !cl && (exp_cnt < TD) && bank_in_ready[wb];
        ie = in_valid && rdy;
        oe = exp_ov && out_ready;
        tk = !cl && ld && bank_out_valid[rb];
        e_biv = '0;
        e_biv[wb] = in_valid && !cl;
        e_bor = '0;
        e_bor[rb] = ld && !cl;
        chk("in_ready", 64'(in_ready), 64'(rdy));
        chk("bank_in_valid", 64'(bank_in_valid), 64'(e_biv));
        chk("bank_out_ready", 64'(bank_out_ready), 64'(e_bor));
        chk("bank_clear", 64'(bank_clear), 64'(cl));
        chk("bank_in_data", 64'(bank_in_data), 64'({NB{in_data}}));
        chk("out_valid", 64'(out_valid), 64'(exp_ov));
        if (exp_ov && ref_q.size() > 0)
            chk("out_data", 64'(out_data), 64'(ref_q[0]));
        chk("count", 64'(count), 64'(exp_cnt));
        biv = bank_in_valid;
        bir = bank_in_ready;
        bov = bank_out_valid;
        bor = bank_out_ready;
        din = in_data;
        ordy = out_ready;
        @(posedge clk);
        #1;
        if (cl) begin
            model_reset();
        end else begin
            for (int i = 0; i < NB; i++) begin
                if (bor[i] && bov[i] && bq[i].size() > 0) void'(bq[i].pop_front());
                if (biv[i] && bir[i]) begin
                    bq[i].push_back(din);
                    blog[i].push_back(din);
                end
            end
            if (oe && ref_q.size() > 0) olog.push_back(ref_q.pop_front());
            if (ie) begin
                ref_q.push_back(din);
                n_wr++;
            end
            exp_cnt += int'(ie) - int'(oe);
            if (tk) begin
                exp_ov = 1'b1;
                n_take++;
            end else if (ordy) begin
                exp_ov = 1'b0;
            end
        end
        drive_banks();
        #1;
    endtask

    task automatic drain();
        in_valid = 1'b0;
        out_ready = 1'b1;
        clear = 1'b0;
        stall_in = '0;
        stall_out = '0;
        for (int k = 0; k < 1200; k++) begin
            if (count == '0 && !out_valid) break;
            step();
        end
        chk("drain_count", 64'(count), 64'd0);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        in_valid = 1'b0;
        step();
        clear = 1'b0;
    endtask

    task automatic write_n(input int n, input logic [DW-1:0] base);
        for (int k = 0; k < n; k++) begin
            in_valid = 1'b1;
            in_data = base + DW'(k);
            step();
        end
        in_valid = 1'b0;
    endtask

    initial begin
        n_pass = 0;
        n_chk = 0;
        rstn = 1'b0;
        in_data = '0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        clear = 1'b0;
        stall_in = '0;
        stall_out = '0;
        model_reset();
        clear_logs();
        drive_banks();
        repeat (2) @(posedge clk);
        #2 rstn = 1'b1;
        #1;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        // 0x01..0x08 back-to-back with the sink always ready
        out_ready = 1'b1;
        write_n(8, 8'h01);
        drain();
        chk("t1_bank0", pack(blog[0]), 64'h01030507);
        chk("t1_bank1", pack(blog[1]), 64'h02040608);
        chk("t1_order", pack(olog), 64'h0102030405060708);

        // fill until full with the sink stalled
        out_ready = 1'b0;
        in_valid = 1'b1;
        for (int k = 0; k < 600; k++) begin
            if (!in_ready) break;
            in_data = DW'($urandom);
            step();
        end
        in_valid = 1'b0;
        chk("fill_stop", 64'(in_ready), 64'd0);
        chk("fill_count", 64'(count), 64'(TD));
        out_ready = 1'b1;
        step();
        chk("fill_pop_count", 64'(count), 64'(TD-1));
        chk("fill_pop_ready", 64'(in_ready), 64'd1);
        drain();

        // read bank 1 stalls: bank 0 data must not bypass
        do_clear();
        clear_logs();
        stall_out = 2'b10;
        out_ready = 1'b1;
        write_n(6, 8'h11);
        repeat (6) step();
        chk("stall_out_valid", 64'(out_valid), 64'd0);
        chk("stall_count", 64'(count), 64'd5);
        chk("stall_delivered", pack(olog), 64'h11);
        stall_out = '0;
        drain();
        chk("stall_order", pack(olog), 64'h111213141516);

        // simultaneous write and read at count 5
        do_clear();
        out_ready = 1'b0;
        write_n(5, 8'h30);
        chk("simul_start", 64'(count), 64'd5);
        in_valid = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 100; k++) begin
            in_data = DW'($urandom);
            step();
            chk("simul_count", 64'(count), 64'd5);
        end
        drain();

        // clear mid-stream at count 7
        do_clear();
        out_ready = 1'b0;
        write_n(7, 8'h50);
        chk("pre_clear_count", 64'(count), 64'd7);
        clear = 1'b1;
        in_valid = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("clear_bank_clear", 64'(bank_clear), 64'd1);
        chk("clear_in_ready", 64'(in_ready), 64'd0);
        step();
        clear = 1'b0;
        chk("post_clear_count", 64'(count), 64'd0);
        chk("post_clear_ov", 64'(out_valid), 64'd0);
        in_data = 8'hA5;
        #1;
        chk("post_clear_bank0", 64'(bank_in_valid), 64'b01);
        step();
        drain();

        // randomized traffic with bank stalls and occasional clear
        for (int k = 0; k < 3000; k++) begin
            in_valid = ($urandom % 4) != 0;
            in_data = DW'($urandom);
            out_ready = ($urandom % 3) != 0;
            stall_in = NB'(($urandom % 8 == 0) ? $urandom : 0);
            stall_out = NB'(($urandom % 8 == 0) ? $urandom : 0);
            clear = ($urandom % 300) == 0;
            step();
        end
        drain();

        // asynchronous reset between edges with data in flight
        out_ready = 1'b0;
        write_n(3, 8'h70);
        #1 rstn = 1'b0;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_count", 64'(count), 64'd0);
        chk("arst_out_data", 64'(out_data), 64'd0);
        model_reset();
        clear_logs();
        drive_banks();
        @(posedge clk);
        #2 rstn = 1'b1;
        in_valid = 1'b1;
        in_data = 8'h5A;
        #1;
        chk("arst_bank0", 64'(bank_in_valid), 64'b01);
        step();
        drain();
        chk("arst_order", pack(olog), 64'h5A);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
